// File: rtl/jt49_env_pkg.sv
// Shared constants and shape helpers for the PSG envelope register front-end.
package jt49_env_pkg;

  localparam int unsigned ENV_PW = 16;

  localparam logic [3:0] ENV_ADDR_FINE   = 4'd11;
  localparam logic [3:0] ENV_ADDR_COARSE = 4'd12;
  localparam logic [3:0] ENV_ADDR_SHAPE  = 4'd13;

  localparam int unsigned CONT = 3;
  localparam int unsigned ATT  = 2;
  localparam int unsigned ALT  = 1;
  localparam int unsigned HOLD = 0;

  typedef struct packed {
    logic cont;
    logic att;
    logic alt;
    logic hold;
  } env_shape_t;

  // Place shape flags at the bit positions the envelope generator expects
  function automatic logic [3:0] env_shape_pack(input env_shape_t s);
    logic [3:0] r;
    r       = 4'h0;
    r[CONT] = s.cont;
    r[ATT]  = s.att;
    r[ALT]  = s.alt;
    r[HOLD] = s.hold;
    return r;
  endfunction

endpackage

// File: rtl/jt49_env_ctrl_if.sv
// CPU-side PSG register bus seen by the envelope register front-end.
interface jt49_env_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs_n, output wr_n, output addr, output din, input  dout);
  modport slave  (input  cs_n, input  wr_n, input  addr, input  din, output dout);
endinterface

// File: rtl/jt49_env_period.sv
// Envelope timebase: cen prescaler, period counter and step square wave.
module jt49_env_period #(
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned PW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [PW-1:0] period,
  input  logic          clr,
  output logic          step,
  output logic          tick
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);

  logic [PRE_W-1:0] pre;
  logic [PW-1:0]    cnt;
  logic             tick_c;
  logic [PW:0]      cnt_inc;
  logic [PW:0]      per_eff;

  assign tick_c  = cen && (pre == PRE_W'(PRESCALE - 1));
  assign cnt_inc = {1'b0, cnt} + (PW+1)'(1);
  // A zero period counts like a period of one
  assign per_eff = (period == '0) ? (PW+1)'(1) : {1'b0, period};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      cnt  <= '0;
      step <= 1'b0;
      tick <= 1'b0;
    end else if (clr) begin
      pre  <= '0;
      cnt  <= '0;
      step <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= tick_c;
      if (cen) pre <= tick_c ? '0 : pre + PRE_W'(1);
      // >= so a period shrunk below the current count wraps on the next tick
      if (tick_c) begin
        if (cnt_inc >= per_eff) begin
          cnt  <= '0;
          step <= ~step;
        end else begin
          cnt <= cnt_inc[PW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/jt49_env_ctrl.sv
// PSG envelope register front-end: R11/R12/R13 decode, restart and timebase.
// Optional readback of the envelope registers when JT49_ENV_READBACK_EN is defined.
module jt49_env_ctrl
  import jt49_env_pkg::*;
#(
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned PW       = ENV_PW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jt49_env_ctrl_if.slave    bus,
  output logic              eg_step,
  output logic              eg_null_period,
  output logic              eg_restart,
  output logic [3:0]        eg_ctrl
);

  logic       wr;
  logic       wr_shape;
  logic [7:0] per_fine;
  logic [7:0] per_coarse;
  env_shape_t shape;
  logic [PW-1:0] period;
  logic       tick_unused;

  assign wr       = !bus.cs_n && !bus.wr_n;
  assign wr_shape = wr && (bus.addr == ENV_ADDR_SHAPE);
  assign period   = PW'({per_coarse, per_fine});
  assign eg_ctrl  = env_shape_pack(shape);

  // Register file, restart pulse and null-period flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_fine       <= 8'h00;
      per_coarse     <= 8'h00;
      shape          <= '0;
      eg_restart     <= 1'b0;
      eg_null_period <= 1'b1;
    end else begin
      eg_restart     <= wr_shape;
      eg_null_period <= (period == '0);
      if (wr && (bus.addr == ENV_ADDR_FINE))   per_fine   <= bus.din;
      if (wr && (bus.addr == ENV_ADDR_COARSE)) per_coarse <= bus.din;
      if (wr_shape)                            shape      <= env_shape_t'(bus.din[3:0]);
    end
  end

`ifdef JT49_ENV_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout <= 8'hFF;
    end else if (!bus.cs_n && bus.wr_n) begin
      case (bus.addr)
        ENV_ADDR_FINE:   bus.dout <= per_fine;
        ENV_ADDR_COARSE: bus.dout <= per_coarse;
        ENV_ADDR_SHAPE:  bus.dout <= {4'h0, shape};
        default:         bus.dout <= 8'hFF;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.dout <= 8'hFF;
    else        bus.dout <= 8'hFF;
  end
`endif

  // A shape write restarts the timebase and wins over a coincident tick
  jt49_env_period #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_period (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .period (period),
    .clr    (wr_shape),
    .step   (eg_step),
    .tick   (tick_unused)
  );

endmodule

// File: doc/jt49_env_ctrl.md
Name: jt49_env_ctrl

Overview:
Register front-end and timebase sequencer for the PSG envelope generator. It holds the envelope period (R11 fine, R12 coarse) and shape (R13) registers, and divides the core clock enable down to envelope ticks. It drives the generator's step, null_period, restart and ctrl[3:0] inputs. It sits between the CPU-side PSG register bus and the envelope generator instance.

Parameters:
PRESCALE, 8, number of cen pulses per envelope-period tick (legal range 2..256).
PW, 16, envelope period width in bits; fixed by R11/R12, not to be overridden.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous reset, active-low
cen  input  1  clock enable from PSG divider
cs_n  input  1  chip select, active-low
wr_n  input  1  write strobe, active-low, sampled on clk
addr  input  4  register address
din  input  8  write data
dout  output  8  read data, registered
eg_step  output  1  square-wave step to envelope generator (generator acts on rising edge)
eg_null_period  output  1  high while period register == 0
eg_restart  output  1  one-clk pulse on R13 write
eg_ctrl  output  4  envelope shape {CONT,ATT,ALT,HOLD}

Behaviour:
- Reset (async): per_fine=0, per_coarse=0, shape=0, pre=0, cnt=0, eg_step=0, eg_restart=0, dout=0xFF. eg_null_period=1 because period=0.
- Write acceptance: cs_n=0 && wr_n=0 on a clk edge. Writes are independent of cen. Only addr 11/12/13 are decoded; other addresses are ignored.
- R11 -> per_fine=din. R12 -> per_coarse=din. period={per_coarse,per_fine}.
- R13 -> shape=din[3:0], eg_ctrl=din[3:0] on the next clk. eg_restart=1 for exactly one clk. pre, cnt and eg_step are cleared in the same edge.
- A write held for N consecutive clks produces N restart pulses. The bench must check this.
- Prescaler: on cen, pre increments. tick = cen && pre==PRESCALE-1, after which pre wraps to 0.
- Period counter, on tick:
  - if cnt+1 >= max(period,1): cnt<=0 and eg_step toggles;
  - else cnt<=cnt+1.
  - Comparison is >=, so shrinking the period below cnt wraps on the next tick.
  - Period 0 behaves as period 1 for counting.
- Step timing: eg_step toggles every period*PRESCALE cen pulses. One generator step therefore occurs every 2*period*PRESCALE cen pulses.
- eg_null_period is registered from period==0 and updates one clk after the R11/R12 write.
- Simultaneous R13 write and tick: the write wins. Counter and step are cleared and the tick is lost.
- R11/R12 write coincident with tick: the tick compares against the old period. The new value takes effect from the next tick.
- Reset mid-operation: all state returns to reset values immediately. No restart pulse is issued on reset release.
- eg_restart is not gated by cen. The generator latches it until its own next cen.

Optional Feature:
JT49_ENV_READBACK_EN.
- Defined: on cs_n=0 && wr_n=1, dout registers per_fine for addr 11, per_coarse for addr 12, and {4'h0,shape} for addr 13. Other addresses return 0xFF. Latency is 1 clk.
- Undefined: dout is held at 0xFF and no read mux is synthesised.

Decomposition:
- Package jt49_env_pkg holds:
  - localparams ENV_ADDR_FINE=4'd11, ENV_ADDR_COARSE=4'd12, ENV_ADDR_SHAPE=4'd13;
  - ENV_PW=16;
  - shape bit indices CONT=3, ATT=2, ALT=1, HOLD=0.
- Sub-module jt49_env_period contains the prescaler, period counter and step toggle. Its inputs are cen, period and clr; its outputs are step and tick.
- The top level keeps register decode, restart generation, null_period and readback.

Test Plan:
- Reset with rst_n low 3 clks -> dout=0xFF, eg_step=0, eg_restart=0, eg_ctrl=0, eg_null_period=1.
- PRESCALE=8, cen every clk, write R11=0x02, R12=0x00 -> eg_null_period falls 1 clk later; eg_step toggles every 16 cen, giving a rising edge every 32 cen.
- Write R13=0xA mid-count -> exactly one clk of eg_restart, eg_ctrl=4'hA, eg_step=0. The next toggle comes a full 16 cen later.
- Period 0x0100, let cnt reach 0x80, then write R11=0x10, R12=0x00 -> wrap and eg_step toggle on the very next tick.
- R13 write coincident with tick -> no toggle, cnt=0. Assert rst_n low during counting -> immediate reset values and no restart pulse after release.
- With JT49_ENV_READBACK_EN defined: write R12=0x5A, then read addr 12 -> dout=0x5A next clk. Read addr 4 -> 0xFF. Undefined: every read -> 0xFF.
